weight_stream_sink: RTL and testbench
=====================================

// Module: weight_stream_sink
// PURPOSE
//   Receiving end of a coefficient stream (ap_fifo read side: dout/empty_n/read).
//   Captures one kernel of KERN_S coefficients into a ping-pong local buffer.
//   Serves the conv datapath through a 1-cycle-latency ROM-style address port.
//   Each loaded kernel is held for REUSE compute passes, then released for refill.
//   Sits between a weight source (ROM streamer or upstream FIFO) and a conv engine.
// PARAMETERS
//   COEFF_W  16  coefficient width in bits (matches `coeff_width)
//   KERN_S   25  coefficients per kernel (bank depth); >= 2
//   REUSE    4   compute passes per kernel before its bank is released; >= 1
// PORTS
//   ap_clk           in   1                  clock, all logic on rising edge
//   ap_rst_n         in   1                  async active-low reset
//   input_V_dout     in   COEFF_W            stream data, valid while empty_n=1
//   input_V_empty_n  in   1                  1 = stream word available
//   input_V_read     out  1                  pop strobe, consumes dout this cycle
//   kern_valid       out  1                  read bank holds a complete kernel
//   rd_addr          in   $clog2(KERN_S)     coefficient index
//   rd_ce            in   1                  read enable
//   rd_q             out  COEFF_W            coefficient, 1 cycle after rd_ce
//   kern_done        in   1                  pulse: one compute pass finished
// BEHAVIOUR
//   Interface: one clock (ap_clk); reset ap_rst_n is asynchronous, active-low.
//   Reset values:
//     - wr_bank=0, rd_bank=0, full[1:0]=0, wr_cnt=0, use_cnt=0, state=S_FILL
//     - rd_q=0, kern_valid=0, input_V_read=0 while in reset
//   Load FSM:
//     - S_FILL: input_V_read = input_V_empty_n (combinational, same-cycle pop).
//       On each pop, bank[wr_bank][wr_cnt] <= dout and wr_cnt++.
//       On the pop with wr_cnt==KERN_S-1: set full[wr_bank], toggle wr_bank, wr_cnt=0.
//       Next state is S_WAIT if full[new wr_bank] is set, else S_FILL.
//     - S_WAIT: input_V_read=0. Go to S_FILL the cycle after full[wr_bank] clears.
//     - Never pops while empty_n=0. Stalls mid-kernel hold wr_cnt indefinitely.
//   Compute side:
//     - kern_valid = full[rd_bank] (registered flag, no comb path from stream).
//     - rd_q <= bank[rd_bank][rd_addr] when rd_ce=1, else holds its value.
//     - rd_addr >= KERN_S returns 0.
//     - Reads with kern_valid=0 return stale bank data; this is legal but undefined.
//   Reuse:
//     - kern_done with kern_valid=1: use_cnt++.
//     - At use_cnt==REUSE-1: clear full[rd_bank], toggle rd_bank, use_cnt=0.
//     - kern_done with kern_valid=0 is ignored.
//   Simultaneous events:
//     - Last-word pop into bank B and release of bank A in the same cycle:
//       both take effect.
//     - If A was the read bank, kern_valid the next cycle reflects full[B]=1.
//     - rd_ce in the same cycle as a release reads the old rd_bank.
//   Throughput: 1 word/cycle sustained; a KERN_S-cycle fill overlaps compute on the
//   other bank.
//   Mid-operation reset: partial kernel discarded, all flags cleared. Upstream words
//   already popped are lost.
// TESTING
//   1. Reset, then stream 0..24 back-to-back -> 25 pops, kern_valid=1 on cycle 26;
//      rd_addr=7 -> rd_q=7 next cycle.
//   2. Stream 50 words with no kern_done -> both banks full; 3rd kernel: read=0
//      (S_WAIT) despite empty_n=1.
//   3. 4 kern_done pulses on bank0 -> bank0 released, rd_bank=1, rd_q from second
//      kernel; loader resumes the cycle after.
//   4. empty_n toggling every cycle -> pops only when empty_n=1; kernel complete after
//      25 pops, values in order.
//   5. Last pop and 4th kern_done in the same cycle -> no word lost; kern_valid stays 1
//      across the swap.
//   6. Assert ap_rst_n low at wr_cnt=12 -> outputs 0 immediately; refill from word 0
//      after release.

Source files
------------

// File: rtl/weight_stream_sink.sv
// weight_stream_sink: ping-pong coefficient buffer fed from an ap_fifo stream, read by address
module weight_stream_sink #(
  parameter int COEFF_W = 16,
  parameter int KERN_S  = 25,
  parameter int REUSE   = 4,
  localparam int AW     = $clog2(KERN_S),
  localparam int UW     = (REUSE > 1) ? $clog2(REUSE) : 1
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [COEFF_W-1:0] input_V_dout,
  input  logic               input_V_empty_n,
  output logic               input_V_read,
  output logic               kern_valid,
  input  logic [AW-1:0]      rd_addr,
  input  logic               rd_ce,
  output logic [COEFF_W-1:0] rd_q,
  input  logic               kern_done
);
  typedef enum logic {S_FILL, S_WAIT} state_t;
  state_t             state_q;
  logic [COEFF_W-1:0] bank_q [2][KERN_S];
  logic [COEFF_W-1:0] rd_data_q;
  logic               wr_bank_q, rd_bank_q;
  logic [1:0]         full_q, full_d;
  logic [AW-1:0]      wr_cnt_q;
  logic [UW-1:0]      use_cnt_q;
  logic               pop, last, use_hit, rel, addr_ok;
  assign input_V_read = ap_rst_n && state_q == S_FILL && input_V_empty_n;
  assign pop          = input_V_read;
  assign last         = pop && wr_cnt_q == AW'(KERN_S - 1);
  assign use_hit      = kern_done && full_q[rd_bank_q];
  assign rel          = use_hit && use_cnt_q == UW'(REUSE - 1);
  assign addr_ok      = {1'b0, rd_addr} < (AW + 1)'(KERN_S);
  assign kern_valid   = full_q[rd_bank_q];
  assign rd_q         = rd_data_q;
  // release and fill always target different banks, so both updates can apply together
  always_comb begin
    full_d = full_q;
    if (rel) full_d[rd_bank_q] = 1'b0;
    if (last) full_d[wr_bank_q] = 1'b1;
  end
  always_ff @(posedge ap_clk) begin
    if (pop) bank_q[wr_bank_q][wr_cnt_q] <= input_V_dout;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= S_FILL;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      wr_cnt_q  <= '0;
      use_cnt_q <= '0;
      rd_data_q <= '0;
    end else begin
      full_q <= full_d;
      if (rd_ce) rd_data_q <= addr_ok ? bank_q[rd_bank_q][rd_addr] : '0;
      if (use_hit) use_cnt_q <= rel ? '0 : use_cnt_q + 1'b1;
      if (rel) rd_bank_q <= ~rd_bank_q;
      if (state_q == S_FILL) begin
        if (pop) wr_cnt_q <= last ? '0 : wr_cnt_q + 1'b1;
        if (last) begin
          wr_bank_q <= ~wr_bank_q;
          state_q   <= full_d[~wr_bank_q] ? S_WAIT : S_FILL;
        end
      end else if (!full_q[wr_bank_q]) begin
        state_q <= S_FILL;
      end
    end
  end
endmodule

// File: tb/tb_weight_stream_sink.sv
// tb_weight_stream_sink: random stream/compute traffic checked against a kernel-queue model
module tb_weight_stream_sink;
  localparam int W = 16, K = 25, R = 4, AW = 5;
  typedef logic [W-1:0] kern_t [K];
  logic          ap_clk = 0, ap_rst_n = 0;
  logic [W-1:0]  dout = '0;
  logic          empty_n = 0, rd_ce = 0, kern_done = 0;
  logic [AW-1:0] rd_addr = '0;
  logic          input_V_read, kern_valid;
  logic [W-1:0]  rd_q;
  int n_chk = 0, n_fail = 0;
  kern_t        q[$];
  logic [W-1:0] part[$];
  logic         m_wait = 0, rq_known = 1, rnd = 0;
  int           m_use = 0;
  logic [W-1:0] exp_rq = '0, cur_word = '0;
  weight_stream_sink #(.COEFF_W(W), .KERN_S(K), .REUSE(R)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .input_V_dout(dout), .input_V_empty_n(empty_n),
    .input_V_read(input_V_read), .kern_valid(kern_valid), .rd_addr(rd_addr), .rd_ce(rd_ce),
    .rd_q(rd_q), .kern_done(kern_done)
  );
  always #5 ap_clk = ~ap_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete(); part.delete();
    m_wait = 0; m_use = 0; exp_rq = '0; rq_known = 1;
  endtask
  task automatic do_reset();
    @(negedge ap_clk);
    empty_n = 1; rd_ce = 1; kern_done = 1;
    ap_rst_n = 0;
    #1;
    chk("rst_read", input_V_read, 0);
    chk("rst_kvalid", kern_valid, 0);
    chk("rst_rdq", rd_q, 0);
    model_reset();
    @(negedge ap_clk);
    ap_rst_n = 1;
  endtask
  task automatic step(input logic e, input logic ce, input logic [AW-1:0] a, input logic kd);
    logic pop;
    int pre;
    kern_t tmp;
    empty_n = e; rd_ce = ce; rd_addr = a; kern_done = kd; dout = cur_word;
    pop = e && !m_wait;
    #1 chk("read", input_V_read, pop);
    @(posedge ap_clk);
    pre = q.size();
    if (ce) begin
      if (a >= K) begin exp_rq = '0; rq_known = 1; end
      else if (pre > 0) begin exp_rq = q[0][a]; rq_known = 1; end
      else rq_known = 0;
    end
    if (m_wait && pre < 2) m_wait = 0;
    if (kd && pre > 0) begin
      m_use++;
      if (m_use == R) begin void'(q.pop_front()); m_use = 0; end
    end
    if (pop) begin
      part.push_back(cur_word);
      if (part.size() == K) begin
        for (int i = 0; i < K; i++) tmp[i] = part[i];
        q.push_back(tmp);
        part.delete();
        if (q.size() == 2) m_wait = 1;
      end
      cur_word = rnd ? W'($urandom) : cur_word + 1'b1;
    end
    @(negedge ap_clk);
    chk("kvalid", kern_valid, q.size() > 0);
    if (rq_known) chk("rd_q", rd_q, exp_rq);
  endtask
  initial begin
    repeat (3) @(negedge ap_clk);
    do_reset();
    empty_n = 0; rd_ce = 0; kern_done = 0;
    for (int i = 0; i < K; i++) step(1, 0, '0, 0);
    step(0, 1, 5'd7, 0);
    chk("t1_rd7", rd_q, 7);
    for (int i = 0; i < K; i++) step(1, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0);
    chk("t2_both_full", q.size(), 2);
    for (int i = 0; i < R; i++) step(1, 0, '0, 1);
    step(1, 1, 5'd3, 0);
    chk("t3_second_kernel", rd_q, K + 3);
    for (int i = 0; i < 60; i++) step(i[0], 1, 5'(i % K), 0);
    for (int i = 0; i < 80 && !(empty_n && !m_wait && part.size() == K - 1 && m_use == R - 1); i++)
      step(1, 1, 5'(i % K), m_use < R - 1 && q.size() > 0 && !(part.size() == K - 1));
    step(1, 1, 5'd24, 1);
    for (int i = 0; i < 40 && part.size() != 12; i++) step(1, 0, '0, i % 2 == 0);
    chk("t6_wrcnt12", part.size(), 12);
    do_reset();
    rnd = 1;
    cur_word = W'($urandom);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom_range(0, 2) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
